// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard types and scan-code constants.
// Used by ps2_rx_frame, ps2_scancode_rx and keyboard_gamepadX.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 deframer: pin synchronizers, clock glitch filter, rx FSM, timeout.
// KBD_PARITY_CHECK_EN enables the odd-parity check on received frames.
module ps2_rx_frame
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_done,
    output logic       o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          flt_q, flt_d;
    rx_state_t     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fall;
    logic          dat;
    logic          par_ok;
`ifdef KBD_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif

    assign dat = dat_sync_q[1];

    // Filtered clock flips only after FILTER_LEN samples disagreeing with it.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], i_ps2_clk};
        dat_sync_d = {dat_sync_q[0], i_ps2_dat};
        flt_cnt_d  = '0;
        flt_d      = flt_q;
        if (clk_sync_q[1] != flt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
        fall = flt_q & ~flt_d;
    end

`ifdef KBD_PARITY_CHECK_EN
    assign par_ok = ^{shreg_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        tmo_d       = tmo_q;
        o_byte_done = 1'b0;
        o_frame_err = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
        par_d       = par_q;
`endif
        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT_CYC)) begin
            tmo_d = tmo_q + 1'b1;
        end
        // A fall takes priority over a timeout expiring in the same cycle.
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d  = {dat, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                    par_d   = dat;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat && par_ok) begin
                        o_byte_done = 1'b1;
                    end else begin
                        o_frame_err = 1'b1;
                    end
                end
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC)) begin
            state_d     = IDLE;
            o_frame_err = 1'b1;
        end
    end

    assign o_byte = shreg_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            flt_cnt_q  <= '0;
            flt_q      <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            tmo_q      <= '0;
`ifdef KBD_PARITY_CHECK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            flt_cnt_q  <= flt_cnt_d;
            flt_q      <= flt_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            tmo_q      <= tmo_d;
`ifdef KBD_PARITY_CHECK_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard front end: strips F0/E0 prefixes, pulses make codes.
// Parity checking is enabled by defining KBD_PARITY_CHECK_EN.
module ps2_scancode_rx
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_key,
    output logic       o_key_ext,
    output logic       o_release,
    output logic [7:0] o_rel_code,
    output logic       o_frame_err
);

    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_err;

    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [7:0] key_q, key_d;
    logic       key_ext_q, key_ext_d;
    logic       rel_q, rel_d;
    logic [7:0] rel_code_q, rel_code_d;
    logic       ferr_q, ferr_d;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_dat   (i_ps2_dat),
        .o_byte      (rx_byte),
        .o_byte_done (rx_done),
        .o_frame_err (rx_err)
    );

    always_comb begin
        brk_d      = brk_q;
        ext_d      = ext_q;
        key_d      = 8'h00;
        key_ext_d  = 1'b0;
        rel_d      = 1'b0;
        rel_code_d = rel_code_q;
        ferr_d     = 1'b0;
        if (rx_err) begin
            ferr_d = 1'b1;
            brk_d  = 1'b0;
            ext_d  = 1'b0;
        end else if (rx_done) begin
            if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                rel_d      = 1'b1;
                rel_code_d = rx_byte;
                brk_d      = 1'b0;
                ext_d      = 1'b0;
            end else begin
                key_d     = rx_byte;
                key_ext_d = ext_q;
                ext_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            key_q      <= 8'h00;
            key_ext_q  <= 1'b0;
            rel_q      <= 1'b0;
            rel_code_q <= 8'h00;
            ferr_q     <= 1'b0;
        end else begin
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            key_q      <= key_d;
            key_ext_q  <= key_ext_d;
            rel_q      <= rel_d;
            rel_code_q <= rel_code_d;
            ferr_q     <= ferr_d;
        end
    end

    assign o_key       = key_q;
    assign o_key_ext   = key_ext_q;
    assign o_release   = rel_q;
    assign o_rel_code  = rel_code_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx with a shortened PS/2 bit period.
// Define KBD_PARITY_CHECK_EN to match the parity-checking build.
module tb_ps2_scancode_rx;

    localparam int H   = 32;
    localparam int TMO = 500;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] o_key;
    logic       o_key_ext;
    logic       o_release;
    logic [7:0] o_rel_code;
    logic       o_frame_err;

    int tests;
    int fails;
    int key_cnt;
    int rel_cnt;
    int err_cnt;
    logic [7:0] last_key;
    logic       last_ext;
    int k0;
    int r0;
    int e0;

    ps2_scancode_rx #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_dat   (ps2_dat),
        .o_key       (o_key),
        .o_key_ext   (o_key_ext),
        .o_release   (o_release),
        .o_rel_code  (o_rel_code),
        .o_frame_err (o_frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Every non-zero o_key cycle counts, so a 2-cycle pulse shows as 2.
    always @(negedge clk) begin
        if (o_key != 8'h00) begin
            key_cnt  = key_cnt + 1;
            last_key = o_key;
            last_ext = o_key_ext;
        end
        if (o_release) rel_cnt = rel_cnt + 1;
        if (o_frame_err) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        k0 = key_cnt;
        r0 = rel_cnt;
        e0 = err_cnt;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_dat = b;
        cyc(H);
        ps2_clk = 1'b0;
        cyc(H);
        ps2_clk = 1'b1;
        if (glitch) begin
            cyc(10);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par,
                        input bit bad_stop, input int glitch_at);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send_bit(f[i], i == glitch_at);
        end
        ps2_dat = 1'b1;
        cyc(H);
    endtask

    task automatic partial(input logic [7:0] b, input int n);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_bit(b[i], 1'b0);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        key_cnt = 0;
        rel_cnt = 0;
        err_cnt = 0;
        last_key = 8'h00;
        last_ext = 1'b0;
        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cyc(5);
        chk("rst_key", 32'(o_key), 32'h00);
        chk("rst_key_ext", 32'(o_key_ext), 32'h0);
        chk("rst_release", 32'(o_release), 32'h0);
        chk("rst_rel_code", 32'(o_rel_code), 32'h00);
        chk("rst_frame_err", 32'(o_frame_err), 32'h0);
        rst_n = 1'b1;
        cyc(20);

        mark();
        send(8'h1C, 0, 0, -1);
        chk("t1_key_cycles", 32'(key_cnt - k0), 32'd1);
        chk("t1_key", 32'(last_key), 32'h1C);
        chk("t1_ext", 32'(last_ext), 32'h0);
        chk("t1_err", 32'(err_cnt - e0), 32'd0);

        mark();
        send(8'hF0, 0, 0, -1);
        send(8'h1C, 0, 0, -1);
        chk("t2_brk_no_key", 32'(key_cnt - k0), 32'd0);
        chk("t2_rel_pulses", 32'(rel_cnt - r0), 32'd1);
        chk("t2_rel_code", 32'(o_rel_code), 32'h1C);
        mark();
        send(8'h1D, 0, 0, -1);
        chk("t2_make_cycles", 32'(key_cnt - k0), 32'd1);
        chk("t2_make_key", 32'(last_key), 32'h1D);
        chk("t2_rel_held", 32'(o_rel_code), 32'h1C);

        mark();
        send(8'hE0, 0, 0, -1);
        send(8'h75, 0, 0, -1);
        chk("t3_ext_cycles", 32'(key_cnt - k0), 32'd1);
        chk("t3_ext_key", 32'(last_key), 32'h75);
        chk("t3_ext_flag", 32'(last_ext), 32'h1);
        mark();
        send(8'hE0, 0, 0, -1);
        send(8'hF0, 0, 0, -1);
        send(8'h75, 0, 0, -1);
        chk("t3_extbrk_no_key", 32'(key_cnt - k0), 32'd0);
        chk("t3_extbrk_rel", 32'(rel_cnt - r0), 32'd1);
        chk("t3_extbrk_code", 32'(o_rel_code), 32'h75);
        mark();
        send(8'h1C, 0, 0, -1);
        chk("t3_ext_cleared", 32'(last_ext), 32'h0);
        chk("t3_after_key", 32'(last_key), 32'h1C);

        mark();
        send(8'h23, 0, 1, -1);
        chk("t4_stop_err", 32'(err_cnt - e0), 32'd1);
        chk("t4_stop_no_key", 32'(key_cnt - k0), 32'd0);
        mark();
        send(8'h23, 0, 0, -1);
        chk("t4_good_cycles", 32'(key_cnt - k0), 32'd1);
        chk("t4_good_key", 32'(last_key), 32'h23);
        mark();
        send(8'h23, 1, 0, -1);
`ifdef KBD_PARITY_CHECK_EN
        chk("t4_par_err", 32'(err_cnt - e0), 32'd1);
        chk("t4_par_no_key", 32'(key_cnt - k0), 32'd0);
`else
        chk("t4_par_err", 32'(err_cnt - e0), 32'd0);
        chk("t4_par_key", 32'(key_cnt - k0), 32'd1);
`endif

        mark();
        partial(8'h1B, 4);
        ps2_dat = 1'b1;
        cyc(TMO + 10);
        chk("t5_tmo_err", 32'(err_cnt - e0), 32'd1);
        chk("t5_tmo_no_key", 32'(key_cnt - k0), 32'd0);
        mark();
        send(8'h1B, 0, 0, -1);
        chk("t5_after_cycles", 32'(key_cnt - k0), 32'd1);
        chk("t5_after_key", 32'(last_key), 32'h1B);
        chk("t5_after_err", 32'(err_cnt - e0), 32'd0);

        mark();
        send(8'h1D, 0, 0, 3);
        chk("t6_glitch_cycles", 32'(key_cnt - k0), 32'd1);
        chk("t6_glitch_key", 32'(last_key), 32'h1D);
        chk("t6_glitch_err", 32'(err_cnt - e0), 32'd0);

        mark();
        send(8'hF0, 0, 0, -1);
        send(8'h5A, 0, 0, -1);
        chk("t6_pre_rel_code", 32'(o_rel_code), 32'h5A);
        send(8'hE0, 0, 0, -1);
        partial(8'h1A, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rel_code", 32'(o_rel_code), 32'h00);
        chk("t6_rst_key", 32'(o_key), 32'h00);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cyc(5);
        rst_n = 1'b1;
        cyc(20);
        mark();
        send(8'h1A, 0, 0, -1);
        chk("t6_post_cycles", 32'(key_cnt - k0), 32'd1);
        chk("t6_post_key", 32'(last_key), 32'h1A);
        chk("t6_post_ext", 32'(last_ext), 32'h0);
        chk("t6_post_err", 32'(err_cnt - e0), 32'd0);
        chk("t6_post_rel", 32'(rel_cnt - r0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
